// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bus for uart_rx_cfg: line input, frame configuration and
// the received-frame result/status outputs.
`timescale 1ns/1ps
interface uart_rx_cfg_if;
  logic [2:0] Baud_Set;
  logic [1:0] Data_Bits;
  logic [1:0] Parity_Mode;
  logic       uart_rx;
  logic [7:0] Data;
  logic       Rx_Done;
  logic       Parity_Err;
  logic       Frame_Err;
  logic       Break_Det;
  logic       Busy;

  // The receiver produces the result bus and consumes config and line.
  modport master (
    input  Baud_Set, Data_Bits, Parity_Mode, uart_rx,
    output Data, Rx_Done, Parity_Err, Frame_Err, Break_Det, Busy
  );

  // The consumer drives config and line, and reads the result bus.
  modport slave (
    output Baud_Set, Data_Bits, Parity_Mode, uart_rx,
    input  Data, Rx_Done, Parity_Err, Frame_Err, Break_Det, Busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-8 data bits, optional even/odd
// parity, baud table derived from CLK_FREQ_HZ, 3-sample majority vote,
// false-start rejection and parity/framing/break reporting.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16
) (
  input logic           Clk,
  input logic           Reset_n,
  uart_rx_cfg_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SAMP_A    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] SAMP_B    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] SAMP_C    = TW'(OVERSAMPLE / 2 + 1);

  localparam logic [DIV_W-1:0] DIV_0 = DIV_W'(CLK_FREQ_HZ / (9600   * OVERSAMPLE) - 1);
  localparam logic [DIV_W-1:0] DIV_1 = DIV_W'(CLK_FREQ_HZ / (19200  * OVERSAMPLE) - 1);
  localparam logic [DIV_W-1:0] DIV_2 = DIV_W'(CLK_FREQ_HZ / (38400  * OVERSAMPLE) - 1);
  localparam logic [DIV_W-1:0] DIV_3 = DIV_W'(CLK_FREQ_HZ / (57600  * OVERSAMPLE) - 1);
  localparam logic [DIV_W-1:0] DIV_4 = DIV_W'(CLK_FREQ_HZ / (115200 * OVERSAMPLE) - 1);
  localparam logic [DIV_W-1:0] DIV_5 = DIV_W'(CLK_FREQ_HZ / (230400 * OVERSAMPLE) - 1);
  localparam logic [DIV_W-1:0] DIV_6 = DIV_W'(CLK_FREQ_HZ / (460800 * OVERSAMPLE) - 1);
  localparam logic [DIV_W-1:0] DIV_7 = DIV_W'(CLK_FREQ_HZ / (921600 * OVERSAMPLE) - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic             sync1, rx_s, rx_d;
  logic             armed;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_sel;
  logic [TW-1:0]    tick_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       baud_l;
  logic [1:0]       bits_l;
  logic [1:0]       par_l;
  logic [7:0]       shift;
  logic             par_bit;
  logic             s0, s1;
  logic [7:0]       data_q;
  logic             done_q, perr_q, ferr_q, brk_q, busy_q;

  logic       tick;
  logic       start_det;
  logic       maj;
  logic       par_en;
  logic [2:0] last_idx;
  logic       par_bad;

  assign tick      = (state != IDLE) && (presc == div_sel);
  assign start_det = (state == IDLE) && armed && rx_d && !rx_s;
  assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign par_en    = (par_l == 2'd1) || (par_l == 2'd2);
  assign last_idx  = {1'b0, bits_l} + 3'd4;
  // Unused upper bits of shift stay 0, so XOR over all 8 covers only data.
  assign par_bad   = par_en && ((^shift ^ par_bit) != (par_l == 2'd2));

  assign bus.Data       = data_q;
  assign bus.Rx_Done    = done_q;
  assign bus.Parity_Err = perr_q;
  assign bus.Frame_Err  = ferr_q;
  assign bus.Break_Det  = brk_q;
  assign bus.Busy       = busy_q;

  // Divisor for the baud rate latched at the start of the current frame.
  always_comb begin
    div_sel = DIV_4;
    case (baud_l)
      3'd0:    div_sel = DIV_0;
      3'd1:    div_sel = DIV_1;
      3'd2:    div_sel = DIV_2;
      3'd3:    div_sel = DIV_3;
      3'd4:    div_sel = DIV_4;
      3'd5:    div_sel = DIV_5;
      3'd6:    div_sel = DIV_6;
      default: div_sel = DIV_7;
    endcase
  end

  // Two-flop synchroniser for the RX pin plus a delay flop for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= bus.uart_rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  // Oversample prescaler: held at 0 while idle, wraps on each tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc <= '0;
    end else if (state == IDLE || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Frame FSM: tick counting, majority sampling, shifting and result registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      armed    <= 1'b1;
      tick_cnt <= '0;
      bit_idx  <= '0;
      baud_l   <= '0;
      bits_l   <= '0;
      par_l    <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      data_q   <= '0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rx_s) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start_det) begin
            baud_l   <= bus.Baud_Set;
            bits_l   <= bus.Data_Bits;
            par_l    <= bus.Parity_Mode;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            state    <= START;
            busy_q   <= 1'b1;
          end
        end
        default: begin
          if (tick) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == SAMP_A) s0 <= rx_s;
            if (tick_cnt == SAMP_B) s1 <= rx_s;
            case (state)
              START: begin
                if (tick_cnt == SAMP_C && maj) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                end else if (tick_cnt == TICK_LAST) begin
                  state <= DATA;
                end
              end
              DATA: begin
                if (tick_cnt == SAMP_C) shift[bit_idx] <= maj;
                if (tick_cnt == TICK_LAST) begin
                  if (bit_idx == last_idx) state <= par_en ? PARITY : STOP;
                  else bit_idx <= bit_idx + 3'd1;
                end
              end
              PARITY: begin
                if (tick_cnt == SAMP_C) par_bit <= maj;
                if (tick_cnt == TICK_LAST) state <= STOP;
              end
              STOP: begin
                if (tick_cnt == SAMP_C) begin
                  data_q <= shift;
                  perr_q <= par_bad;
                  ferr_q <= !maj;
                  brk_q  <= (shift == 8'd0) && !(par_en && par_bit) && !maj;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
                  if (!maj) armed <= 1'b0;
                end
              end
              default: begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg at 50 MHz / 115200 baud (432 clocks/bit).
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int BIT_CLKS = 432;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } rec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   done_count;
  rec_t exp_q[$];
  rec_t got_q[$];
  rec_t mon_r;

  uart_rx_cfg_if bus ();

  uart_rx_cfg #(
    .CLK_FREQ_HZ(50000000),
    .OVERSAMPLE (16),
    .DIV_W      (16)
  ) dut (
    .Clk    (clk),
    .Reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Capture every completed frame into the received queue.
  always @(negedge clk) begin
    if (bus.Rx_Done === 1'b1) begin
      mon_r.data = bus.Data;
      mon_r.perr = bus.Parity_Err;
      mon_r.ferr = bus.Frame_Err;
      mon_r.brk  = bus.Break_Det;
      got_q.push_back(mon_r);
      done_count++;
    end
  end

  // Overall time limit.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  function automatic rec_t model(input logic [7:0] d, input int nbits, input int mode,
                                 input logic pbit, input logic stop_bit);
    rec_t r;
    logic [7:0] m;
    logic pen;
    m = '0;
    for (int i = 0; i < nbits; i++) m[i] = d[i];
    pen    = (mode == 1) || (mode == 2);
    r.data = m;
    r.perr = pen && ((mode == 1) ? (^m ^ pbit) : !(^m ^ pbit));
    r.ferr = !stop_bit;
    r.brk  = (m == 8'd0) && !(pen && pbit) && !stop_bit;
    return r;
  endfunction

  function automatic logic parity_for(input logic [7:0] d, input int nbits, input int mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < nbits; i++) x = x ^ d[i];
    return (mode == 2) ? !x : x;
  endfunction

  task automatic idle_bits(input int n);
    bus.uart_rx = 1'b1;
    repeat (n * BIT_CLKS) @(posedge clk);
  endtask

  task automatic drive_bit(input logic b, input bit spike);
    bus.uart_rx = b;
    if (spike) begin
      repeat (243) @(posedge clk);
      bus.uart_rx = !b;
      @(posedge clk);
      bus.uart_rx = b;
      repeat (188) @(posedge clk);
    end else begin
      repeat (BIT_CLKS) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                            input logic pbit, input logic stop_bit, input int spike_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], i == spike_bit);
    if (has_par) drive_bit(pbit, 1'b0);
    drive_bit(stop_bit, 1'b0);
    bus.uart_rx = 1'b1;
  endtask

  task automatic collect(output bit ok, output rec_t g, output rec_t e);
    int n;
    n  = 0;
    ok = 1'b0;
    g  = '0;
    e  = '0;
    while (got_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (got_q.size() > 0) begin
      g  = got_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic applyStimulus_cfg(input logic [1:0] bits, input logic [1:0] pmode);
    bus.Baud_Set    = 3'd4;
    bus.Data_Bits   = bits;
    bus.Parity_Mode = pmode;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.Data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", bus.Data); end
    checks++; if (bus.Rx_Done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.Rx_Done); end
    checks++; if (bus.Parity_Err !== 1'b0) begin failures++; $display("[TB] FAIL reset_perr got=%b exp=0", bus.Parity_Err); end
    checks++; if (bus.Frame_Err !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr got=%b exp=0", bus.Frame_Err); end
    checks++; if (bus.Break_Det !== 1'b0) begin failures++; $display("[TB] FAIL reset_brk got=%b exp=0", bus.Break_Det); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.Busy); end
  endtask

  task automatic test_back_to_back();
    rec_t g, e;
    bit ok;
    int d0;
    applyStimulus_cfg(2'd3, 2'd0);
    idle_bits(1);
    d0 = done_count;
    exp_q.push_back(model(8'hA5, 8, 0, 1'b0, 1'b1));
    exp_q.push_back(model(8'h3C, 8, 0, 1'b0, 1'b1));
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, -1);
    idle_bits(1);
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL b2b_first got=%h (valid=%b) exp=%h", g, ok, e); end
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL b2b_second got=%h (valid=%b) exp=%h", g, ok, e); end
    checks++; if (done_count - d0 != 2) begin failures++; $display("[TB] FAIL b2b_pulses got=%0d exp=2", done_count - d0); end
  endtask

  task automatic test_parity_even();
    rec_t g, e;
    bit ok;
    logic p;
    applyStimulus_cfg(2'd0, 2'd1);
    p = parity_for(8'h13, 5, 1);
    exp_q.push_back(model(8'h13, 5, 1, p, 1'b1));
    send_frame(8'h13, 5, 1'b1, p, 1'b1, -1);
    idle_bits(1);
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL even_good got=%h (valid=%b) exp=%h", g, ok, e); end
    exp_q.push_back(model(8'h13, 5, 1, !p, 1'b1));
    send_frame(8'h13, 5, 1'b1, !p, 1'b1, -1);
    idle_bits(1);
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL even_flipped got=%h (valid=%b) exp=%h", g, ok, e); end
  endtask

  task automatic test_parity_odd_baud_change();
    rec_t g, e;
    bit ok;
    logic p;
    applyStimulus_cfg(2'd3, 2'd2);
    p = parity_for(8'hFF, 8, 2);
    exp_q.push_back(model(8'hFF, 8, 2, p, 1'b1));
    fork
      send_frame(8'hFF, 8, 1'b1, p, 1'b1, -1);
      begin
        repeat (3 * BIT_CLKS) @(posedge clk);
        bus.Baud_Set = 3'd0;
      end
    join
    idle_bits(1);
    bus.Baud_Set = 3'd4;
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL odd_baud_change got=%h (valid=%b) exp=%h", g, ok, e); end
  endtask

  task automatic test_frame_and_break();
    rec_t g, e;
    bit ok;
    int d0;
    applyStimulus_cfg(2'd3, 2'd0);
    exp_q.push_back(model(8'h55, 8, 0, 1'b0, 1'b0));
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, -1);
    idle_bits(1);
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL frame_err got=%h (valid=%b) exp=%h", g, ok, e); end
    d0 = done_count;
    exp_q.push_back(model(8'h00, 8, 0, 1'b0, 1'b0));
    bus.uart_rx = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    idle_bits(2);
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL break got=%h (valid=%b) exp=%h", g, ok, e); end
    checks++; if (done_count - d0 != 1) begin failures++; $display("[TB] FAIL break_pulses got=%0d exp=1", done_count - d0); end
  endtask

  task automatic test_glitch();
    rec_t g, e;
    bit ok;
    int d0;
    applyStimulus_cfg(2'd3, 2'd0);
    d0 = done_count;
    bus.uart_rx = 1'b0;
    repeat (27) @(posedge clk);
    bus.uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (bus.Busy !== 1'b1) begin failures++; $display("[TB] FAIL glitch_busy_seen got=%b exp=1", bus.Busy); end
    idle_bits(2);
    @(negedge clk);
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_clear got=%b exp=0", bus.Busy); end
    checks++; if (done_count != d0) begin failures++; $display("[TB] FAIL glitch_no_done got=%0d exp=0", done_count - d0); end
    exp_q.push_back(model(8'h00, 8, 0, 1'b0, 1'b1));
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 3);
    idle_bits(1);
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL spike_vote got=%h (valid=%b) exp=%h", g, ok, e); end
  endtask

  task automatic test_reset_mid_frame();
    rec_t g, e;
    bit ok;
    int d0;
    logic [7:0] pd;
    applyStimulus_cfg(2'd3, 2'd0);
    exp_q.push_back(model(8'h7E, 8, 0, 1'b0, 1'b0));
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, -1);
    idle_bits(1);
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL pre_reset_frame got=%h (valid=%b) exp=%h", g, ok, e); end
    d0 = done_count;
    pd = 8'hE5;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(pd[i], 1'b0);
    bus.uart_rx = pd[4];
    repeat (200) @(posedge clk);
    reset_n = 1'b0;
    bus.uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.Data, bus.Rx_Done, bus.Parity_Err, bus.Frame_Err, bus.Break_Det, bus.Busy} !== 13'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs got data=%h done=%b pe=%b fe=%b bd=%b busy=%b exp all 0",
               bus.Data, bus.Rx_Done, bus.Parity_Err, bus.Frame_Err, bus.Break_Det, bus.Busy);
    end
    reset_n = 1'b1;
    idle_bits(2);
    @(negedge clk);
    checks++; if (done_count != d0) begin failures++; $display("[TB] FAIL mid_reset_no_done got=%0d exp=0", done_count - d0); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_busy got=%b exp=0", bus.Busy); end
    exp_q.push_back(model(8'h81, 8, 0, 1'b0, 1'b1));
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1);
    idle_bits(1);
    collect(ok, g, e);
    checks++; if (!ok || g !== e) begin failures++; $display("[TB] FAIL post_reset_frame got=%h (valid=%b) exp=%h", g, ok, e); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    done_count  = 0;
    reset_n     = 1'b0;
    bus.uart_rx = 1'b1;
    applyStimulus_cfg(2'd3, 2'd0);
    test_reset();
    test_back_to_back();
    test_parity_even();
    test_parity_odd_baud_change();
    test_frame_and_break();
    test_glitch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
